// File: rtl/midi_pkg.sv
// Shared MIDI/DDS constants and scheduler state encodings.
// Imported by the voice increment scheduler.
package midi_pkg;

  localparam int NOTE_W     = 7;
  localparam int INCR_W_DEF = 24;

  localparam logic [NOTE_W-1:0] NOTE_SILENT = '0;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/voice_incr_scheduler.sv
// Round-robin scheduler that maps per-voice notes to DDS phase
// increments through one shared, externally instantiated ROM.
module voice_incr_scheduler
  import midi_pkg::*;
#(
  parameter int NUM_DDS = 2,
  parameter int INCR_W  = INCR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NOTE_W*NUM_DDS-1:0] note_values,
  input  logic [NOTE_W*NUM_DDS-1:0] velocity_values,
  output logic                      rom_rd_en,
  output logic [NOTE_W-1:0]         rom_addr,
  input  logic [INCR_W-1:0]         rom_data,
  output logic [INCR_W*NUM_DDS-1:0] phase_incr,
  output logic [NOTE_W*NUM_DDS-1:0] amp,
  output logic [NUM_DDS-1:0]        voice_update,
  output logic                      busy
);

  localparam int IDX_W = (NUM_DDS > 1) ? $clog2(NUM_DDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DDS - 1);

  sched_state_t      state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic [NOTE_W-1:0] snap_note;
  logic [NOTE_W-1:0] last_note [NUM_DDS];
  logic [NOTE_W-1:0] cur_note;
  logic [NOTE_W-1:0] cur_vel;
  logic              note_chg;

  // Current voice view and the single-cycle ROM strobe from SCAN.
  always_comb begin
    cur_note  = note_values[idx*NOTE_W +: NOTE_W];
    cur_vel   = velocity_values[idx*NOTE_W +: NOTE_W];
    note_chg  = (cur_note != last_note[idx]);
    nxt_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    rom_addr  = cur_note;
    rom_rd_en = (state == ST_SCAN) && !rst && note_chg &&
                (cur_note != NOTE_SILENT);
  end

  // Scan/read/write FSM with registered voice outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SCAN;
      idx          <= '0;
      snap_note    <= '0;
      phase_incr   <= '0;
      amp          <= '0;
      voice_update <= '0;
      busy         <= 1'b0;
      for (int i = 0; i < NUM_DDS; i++) begin
        last_note[i] <= '0;
      end
    end else begin
      voice_update <= '0;
      unique case (state)
        ST_SCAN: begin
          amp[idx*NOTE_W +: NOTE_W] <=
            (cur_note == NOTE_SILENT) ? '0 : cur_vel;
          if (!note_chg) begin
            idx <= nxt_idx;
          end else if (cur_note == NOTE_SILENT) begin
            phase_incr[idx*INCR_W +: INCR_W] <= '0;
            last_note[idx]    <= NOTE_SILENT;
            voice_update[idx] <= 1'b1;
            idx               <= nxt_idx;
          end else begin
            snap_note <= cur_note;
            busy      <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          phase_incr[idx*INCR_W +: INCR_W] <= rom_data;
          last_note[idx]    <= snap_note;
          voice_update[idx] <= 1'b1;
          state             <= ST_WRITE;
        end
        ST_WRITE: begin
          idx   <= nxt_idx;
          busy  <= 1'b0;
          state <= ST_SCAN;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_incr_scheduler.sv
// Self-checking bench for voice_incr_scheduler, NUM_DDS=2,
// with a 1-cycle ROM model returning 1000*addr.
module tb_voice_incr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] note_values;
  logic [13:0] velocity_values;
  logic        rom_rd_en;
  logic [6:0]  rom_addr;
  logic [23:0] rom_data;
  logic [47:0] phase_incr;
  logic [13:0] amp;
  logic [1:0]  voice_update;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int addr_q[$];
  int exp_q0[$];
  int exp_q1[$];
  logic [6:0] m_note0, m_note1;

  typedef struct {
    logic [6:0] n0, v0, n1, v1;
    int e0, e1, a0, a1;
  } vec_t;

  vec_t tbl[8];

  voice_incr_scheduler #(.NUM_DDS(2), .INCR_W(24)) dut (
    .clk(clk),
    .rst(rst),
    .note_values(note_values),
    .velocity_values(velocity_values),
    .rom_rd_en(rom_rd_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .phase_incr(phase_incr),
    .amp(amp),
    .voice_update(voice_update),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= 24'(1000 * int'(rom_addr));
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: ROM reads and voice writes popped as they happen.
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_rd_en) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL rd_while_busy: got 1 expected 0");
        end
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got addr %0d expected none",
                   rom_addr);
        end else begin
          int e;
          e = addr_q.pop_front();
          if (int'(rom_addr) != e) begin
            errors++;
            $display("FAIL rom_addr: got %0d expected %0d", rom_addr, e);
          end
        end
      end
      if (voice_update[0]) begin
        checks++;
        if (exp_q0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_upd0: got %0d expected none",
                   phase_incr[23:0]);
        end else begin
          int e;
          e = exp_q0.pop_front();
          if (int'(phase_incr[23:0]) != e) begin
            errors++;
            $display("FAIL upd0: got %0d expected %0d",
                     phase_incr[23:0], e);
          end
        end
      end
      if (voice_update[1]) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_upd1: got %0d expected none",
                   phase_incr[47:24]);
        end else begin
          int e;
          e = exp_q1.pop_front();
          if (int'(phase_incr[47:24]) != e) begin
            errors++;
            $display("FAIL upd1: got %0d expected %0d",
                     phase_incr[47:24], e);
          end
        end
      end
    end
  end

  task automatic set_notes(input logic [6:0] n0, v0, n1, v1);
    note_values     = {n1, n0};
    velocity_values = {v1, v0};
  endtask

  task automatic drive(input logic [6:0] n0, v0, n1, v1);
    set_notes(n0, v0, n1, v1);
    if (n0 != m_note0) begin
      exp_q0.push_back(int'(n0) * 1000);
      if (n0 != 0) addr_q.push_back(int'(n0));
      m_note0 = n0;
    end
    if (n1 != m_note1) begin
      exp_q1.push_back(int'(n1) * 1000);
      if (n1 != 0) addr_q.push_back(int'(n1));
      m_note1 = n1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_notes(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_note0 = 0;
    m_note1 = 0;
    addr_q.delete();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic chk_empty(input string name);
    chk(name, addr_q.size() + exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_incr"}, phase_incr, 0);
    chk({name, "_amp"}, amp, 0);
    chk({name, "_upd"}, voice_update, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_rd"}, rom_rd_en, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{7'd60,  7'd100, 7'd0,  7'd50,  60000,  0,     100, 0};
    tbl[1] = '{7'd60,  7'd100, 7'd64, 7'd80,  60000,  64000, 100, 80};
    tbl[2] = '{7'd0,   7'd64,  7'd64, 7'd80,  0,      64000, 0,   80};
    tbl[3] = '{7'd127, 7'd1,   7'd64, 7'd80,  127000, 64000, 1,   80};
    tbl[4] = '{7'd127, 7'd1,   7'd1,  7'd127, 127000, 1000,  1,   127};
    tbl[5] = '{7'd127, 7'd90,  7'd1,  7'd127, 127000, 1000,  90,  127};
    tbl[6] = '{7'd127, 7'd90,  7'd0,  7'd127, 127000, 0,     90,  0};
    tbl[7] = '{7'd0,   7'd90,  7'd0,  7'd127, 0,      0,     0,   0};

    rst = 1'b1;
    m_note0 = 0;
    m_note1 = 0;
    set_notes(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");

    // Idle for 100 cycles: no reads, outputs stay zero.
    do_reset();
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk_zero("idle");

    // Single note: read at t, write visible at t+2.
    do_reset();
    drive(7'd60, 7'd100, 7'd0, 7'd0);
    @(negedge clk);
    chk("t_rd", rom_rd_en, 1);
    chk("t_addr", rom_addr, 60);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t2_incr0", phase_incr[23:0], 60000);
    chk("t2_upd", voice_update, 2'b01);
    chk("t2_amp0", amp[6:0], 100);
    chk("t2_busy", busy, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_empty("single_q");

    // Table of steady-state vectors.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].n0, tbl[i].v0, tbl[i].n1, tbl[i].v1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_incr0", i), phase_incr[23:0], tbl[i].e0);
      chk($sformatf("row%0d_incr1", i), phase_incr[47:24], tbl[i].e1);
      chk($sformatf("row%0d_amp0", i), amp[6:0], tbl[i].a0);
      chk($sformatf("row%0d_amp1", i), amp[13:7], tbl[i].a1);
      chk_empty($sformatf("row%0d_q", i));
    end

    // Both voices change together: 60 then 64 within 7 cycles.
    do_reset();
    drive(7'd60, 7'd10, 7'd64, 7'd20);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("dual_incr0", phase_incr[23:0], 60000);
    chk("dual_incr1", phase_incr[47:24], 64000);
    chk_empty("dual_q");

    // Note changes during READ: old value written, new one next visit.
    do_reset();
    drive(7'd60, 7'd10, 7'd0, 7'd0);
    @(posedge clk);
    #1;
    set_notes(7'd62, 7'd10, 7'd0, 7'd0);
    addr_q.push_back(62);
    exp_q0.push_back(62000);
    m_note0 = 7'd62;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("chg_incr0", phase_incr[23:0], 62000);
    chk_empty("chg_q");

    // Voice1 glitches and returns before its visit: no read.
    do_reset();
    drive(7'd60, 7'd10, 7'd0, 7'd0);
    set_notes(7'd60, 7'd10, 7'd70, 7'd5);
    @(posedge clk);
    #1;
    set_notes(7'd60, 7'd10, 7'd0, 7'd5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch_incr1", phase_incr[47:24], 0);
    chk("glitch_incr0", phase_incr[23:0], 60000);
    chk_empty("glitch_q");

    // Reset during READ aborts the write; read reissues after.
    do_reset();
    drive(7'd60, 7'd100, 7'd0, 7'd0);
    addr_q.push_back(60);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("rst_read");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reissue_rd", rom_rd_en, 1);
    chk("reissue_addr", rom_addr, 60);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("reissue_incr0", phase_incr[23:0], 60000);
    chk_empty("reissue_q");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
